// File: rtl/io_input_cond.sv
// io_input_cond
//   Conditions raw board switches and push-buttons before they reach the
//   core's io_sw_i / io_push_i load path. Each of the 64 bits (32 switch, 32
//   push) passes through a SYNC_STAGES-deep synchronizer and then a
//   tick-sampled stability debouncer. A shared prescaler produces the sample
//   tick. Every output is a flop, so there is no combinational path from the
//   raw pins to the core.
//
//   Optional build macro: IO_PUSH_ACTIVE_LOW_EN
//     defined   -> push_raw_i is inverted ahead of the synchronizer (active-low
//                  keys); the push outputs stay 1 = pressed.
//     undefined -> push_raw_i is taken as is (1 = pressed).
//   sw_raw_i is never inverted.
//
// Ports
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   sw_raw_i     raw asynchronous switch inputs
//   push_raw_i   raw asynchronous push-button inputs
//   io_sw_o      debounced switch levels
//   io_push_o    debounced push levels (1 = pressed)
//   push_rise_o  one-cycle pulse, the cycle after io_push_o[i] rises
//   tick_o       one-cycle debounce sample tick
module io_input_cond #(
  parameter int CLK_DIV     = 50000,
  parameter int STABLE_CNT  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] sw_raw_i,
  input  logic [31:0] push_raw_i,
  output logic [31:0] io_sw_o,
  output logic [31:0] io_push_o,
  output logic [31:0] push_rise_o,
  output logic        tick_o
);

  localparam int NB = 64;
  localparam int CW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);
  localparam logic [PW-1:0] DIV_LAST = PW'(CLK_DIV - 1);

  // Bit order everywhere below: [31:0] switches, [63:32] push-buttons.
  logic [31:0]   push_cond;
  logic [NB-1:0] raw_cond;

`ifdef IO_PUSH_ACTIVE_LOW_EN
  assign push_cond = ~push_raw_i;
`else
  assign push_cond = push_raw_i;
`endif

  assign raw_cond = {push_cond, sw_raw_i};

  // ---------------------------------------------------------------------
  // Synchronizer: stage 0 takes the raw pins, the last stage is the sample.
  // ---------------------------------------------------------------------
  logic [NB-1:0] sync_q [SYNC_STAGES];
  logic [NB-1:0] sample;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= raw_cond;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sample = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------
  // Prescaler. tick_q is registered from the next count so it is high in
  // exactly the cycles where div_q == CLK_DIV-1, yet still cleared by reset
  // (with CLK_DIV=1 it goes high from the first edge after release).
  // ---------------------------------------------------------------------
  logic [PW-1:0] div_q;
  logic [PW-1:0] div_next;
  logic          tick_q;

  always_comb begin
    div_next = div_q + PW'(1);
    if (div_q == DIV_LAST) div_next = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_next;
      tick_q <= (div_next == DIV_LAST);
    end
  end

  // ---------------------------------------------------------------------
  // Debouncer. On a tick, a bit that still disagrees with its output after
  // STABLE_CNT consecutive ticks flips; any agreeing tick restarts the run.
  // The counter tops out at STABLE_CNT-1, so it never wraps.
  // ---------------------------------------------------------------------
  logic [NB-1:0] db_q;
  logic [CW-1:0] cnt_q [NB];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      db_q <= '0;
      for (int b = 0; b < NB; b++) cnt_q[b] <= '0;
    end else if (tick_q) begin
      for (int b = 0; b < NB; b++) begin
        if (sample[b] == db_q[b]) begin
          cnt_q[b] <= '0;
        end else if (cnt_q[b] == CNT_LAST) begin
          db_q[b]  <= sample[b];
          cnt_q[b] <= '0;
        end else begin
          cnt_q[b] <= cnt_q[b] + CW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Press pulse: compares the debounced push level with its value one cycle
  // earlier. Both start at 0 out of reset, so release never pulses.
  // ---------------------------------------------------------------------
  logic [31:0] push_prev_q;
  logic [31:0] push_rise_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      push_prev_q <= '0;
      push_rise_q <= '0;
    end else begin
      push_prev_q <= db_q[63:32];
      push_rise_q <= db_q[63:32] & ~push_prev_q;
    end
  end

  assign io_sw_o     = db_q[31:0];
  assign io_push_o   = db_q[63:32];
  assign push_rise_o = push_rise_q;
  assign tick_o      = tick_q;

endmodule

// File: tb/tb_io_input_cond.sv
// Bench for io_input_cond. Two instances share the stimulus:
//   a: CLK_DIV=4, STABLE_CNT=3, SYNC_STAGES=2
//   b: CLK_DIV=1, STABLE_CNT=1, SYNC_STAGES=2
// A reference model (history of raw inputs, tick from an edge count, per-bit
// run length of disagreeing ticks) is compared with both instances every
// cycle, alongside directed checks with hand-derived constants.
module tb_io_input_cond;

  localparam int DIV_A = 4;
  localparam int STB_A = 3;
  localparam int SYN_A = 2;
  localparam int DIV_B = 1;
  localparam int STB_B = 1;
  localparam int SYN_B = 2;

  localparam int P_DIV [2] = '{DIV_A, DIV_B};
  localparam int P_STB [2] = '{STB_A, STB_B};
  localparam int P_SYN [2] = '{SYN_A, SYN_B};

`ifdef IO_PUSH_ACTIVE_LOW_EN
  localparam logic [31:0] PUSH_XOR = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] PUSH_XOR = 32'h0000_0000;
`endif

  // ------------------------------------------------------------------
  // Clock / reset
  // ------------------------------------------------------------------
  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic [31:0] sw_raw   = '0;
  logic [31:0] push_raw = PUSH_XOR;

  always #5 clk = ~clk;

  logic [31:0] sw_a, push_a, rise_a;
  logic        tick_a;
  logic [31:0] sw_b, push_b, rise_b;
  logic        tick_b;

  io_input_cond #(.CLK_DIV(DIV_A), .STABLE_CNT(STB_A), .SYNC_STAGES(SYN_A)) u_dut_a (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .sw_raw_i    (sw_raw),
    .push_raw_i  (push_raw),
    .io_sw_o     (sw_a),
    .io_push_o   (push_a),
    .push_rise_o (rise_a),
    .tick_o      (tick_a)
  );

  io_input_cond #(.CLK_DIV(DIV_B), .STABLE_CNT(STB_B), .SYNC_STAGES(SYN_B)) u_dut_b (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .sw_raw_i    (sw_raw),
    .push_raw_i  (push_raw),
    .io_sw_o     (sw_b),
    .io_push_o   (push_b),
    .push_rise_o (rise_b),
    .tick_o      (tick_b)
  );

  // ------------------------------------------------------------------
  // Reference model
  // ------------------------------------------------------------------
  logic [63:0] m_out    [2];
  logic [31:0] m_rise   [2];
  logic [31:0] m_prev   [2];
  logic        m_tick   [2];
  int          m_streak [2][64];
  logic [63:0] m_hist   [2][8];   // [0] = raw value taken at the latest edge
  int          m_edges;

  always @(posedge clk or negedge rst_n) begin : ref_model
    logic [63:0] samp;
    logic [63:0] raw_now;
    if (!rst_n) begin
      m_edges = 0;
      for (int k = 0; k < 2; k++) begin
        m_out[k]  = '0;
        m_rise[k] = '0;
        m_prev[k] = '0;
        m_tick[k] = 1'b0;
        for (int j = 0; j < 8; j++) m_hist[k][j] = '0;
        for (int b = 0; b < 64; b++) m_streak[k][b] = 0;
      end
    end else begin
      m_edges++;
      raw_now = {push_raw ^ PUSH_XOR, sw_raw};
      for (int k = 0; k < 2; k++) begin
        // synced sample seen before this edge: raw from SYNC_STAGES edges back
        samp = m_hist[k][P_SYN[k]-1];
        m_rise[k] = m_out[k][63:32] & ~m_prev[k];
        m_prev[k] = m_out[k][63:32];
        if (m_tick[k]) begin
          for (int b = 0; b < 64; b++) begin
            if (samp[b] != m_out[k][b]) begin
              m_streak[k][b]++;
              if (m_streak[k][b] == P_STB[k]) begin
                m_out[k][b]    = samp[b];
                m_streak[k][b] = 0;
              end
            end else begin
              m_streak[k][b] = 0;
            end
          end
        end
        for (int j = 7; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
        m_hist[k][0] = raw_now;
        m_tick[k] = ((m_edges % P_DIV[k]) == (P_DIV[k] - 1));
      end
    end
  end

  // ------------------------------------------------------------------
  // Scoreboard helpers
  // ------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("model_sw_a",   sw_a,             m_out[0][31:0]);
    chk("model_push_a", push_a,           m_out[0][63:32]);
    chk("model_rise_a", rise_a,           m_rise[0]);
    chk("model_tick_a", {31'b0, tick_a},  {31'b0, m_tick[0]});
    chk("model_sw_b",   sw_b,             m_out[1][31:0]);
    chk("model_push_b", push_b,           m_out[1][63:32]);
    chk("model_rise_b", rise_b,           m_rise[1]);
    chk("model_tick_b", {31'b0, tick_b},  {31'b0, m_tick[1]});
  endtask

  // Advance n cycles, checking against the model at each falling edge.
  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      check_model();
    end
  endtask

  // Drive inputs in "pressed" terms; push_raw carries board polarity.
  task automatic set_in(input logic [31:0] sw, input logic [31:0] pressed);
    sw_raw   = sw;
    push_raw = pressed ^ PUSH_XOR;
  endtask

  // ------------------------------------------------------------------
  // Stimulus
  // ------------------------------------------------------------------
  initial begin : stim
    int n;
    int pulses;
    int ticks;
    int first;

    rst_n = 1'b0;
    set_in('0, '0);
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_sw_a",   sw_a,            32'h0);
    chk("rst_push_a", push_a,          32'h0);
    chk("rst_rise_a", rise_a,          32'h0);
    chk("rst_tick_a", {31'b0, tick_a}, 32'h0);
    chk("rst_tick_b", {31'b0, tick_b}, 32'h0);
    check_model();

    // Release at a falling edge; instance a ticks after rising edges 3, 7,
    // instance b after every edge.
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      run(1);
      chk("tick_sched_a", {31'b0, tick_a}, (i % DIV_A == DIV_A - 1) ? 32'd1 : 32'd0);
      chk("tick_const_b", {31'b0, tick_b}, 32'd1);
      chk("idle_sw_a",    sw_a,            32'h0);
    end

    // Switch pattern 0xA5 held stable
    set_in(32'h0000_00A5, 32'h0);
    pulses = 0;
    ticks  = 0;
    first  = 0;
    for (int i = 1; i <= 20; i++) begin
      run(1);
      if (i == 2) chk("fast_sw_before", sw_b, 32'h0);
      if (i == 3) chk("fast_sw_follow", sw_b, 32'h0000_00A5);
      if (first == 0 && sw_a == 32'h0000_00A5) begin
        first = i;
        chk("sw_a5_tick_count", ticks, STB_A);
      end
      if (i >= SYN_A && first == 0 && tick_a) ticks++;
      if (rise_a != 32'h0) pulses++;
    end
    chk("sw_a5_level",   sw_a,   32'h0000_00A5);
    chk("sw_a5_no_rise", pulses, 32'd0);

    // Push bit 0 bounces 1,0 on tick-aligned intervals, then holds 1
    n = 0;
    while (!tick_a && n < 8) begin
      run(1);
      n++;
    end
    chk("align_tick", {31'b0, tick_a}, 32'd1);
    set_in(32'h0000_00A5, 32'h1);
    run(4);
    chk("bounce_hold_1", push_a, 32'h0);
    set_in(32'h0000_00A5, 32'h0);
    run(4);
    chk("bounce_hold_2", push_a, 32'h0);
    set_in(32'h0000_00A5, 32'h1);
    pulses = 0;
    first  = 0;
    for (int i = 1; i <= 20; i++) begin
      run(1);
      if (rise_a[0]) pulses++;
      if (push_a[0] && first == 0) first = i;
    end
    chk("press_level",     push_a, 32'h1);
    chk("press_one_pulse", pulses, 32'd1);
    chk("press_latency",   first,  32'd13);

    // Release: level falls, no pulse
    set_in(32'h0000_00A5, 32'h0);
    pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      run(1);
      if (rise_a != 32'h0) pulses++;
    end
    chk("release_level",    push_a, 32'h0);
    chk("release_no_pulse", pulses, 32'd0);

    // Switches and all pushes change in the same cycle
    set_in(32'h1234_5678, 32'hFFFF_FFFF);
    n = 0;
    while (push_a !== 32'hFFFF_FFFF && n < 24) begin
      run(1);
      n++;
    end
    chk("simul_push", push_a, 32'hFFFF_FFFF);
    chk("simul_sw",   sw_a,   32'h1234_5678);
    run(1);
    chk("simul_rise", rise_a, 32'hFFFF_FFFF);
    run(1);
    chk("simul_rise_end", rise_a, 32'h0);

    // Reset after two differing ticks of a switch change
    set_in(32'hFF00_FF00, 32'hFFFF_FFFF);
    ticks = 0;
    n     = 0;
    while (ticks < 2 && n < 16) begin
      run(1);
      n++;
      if (n >= SYN_A && tick_a) ticks++;
    end
    chk("mid_ticks_seen", ticks, 32'd2);
    run(1);
    chk("mid_sw_hold", sw_a, 32'h1234_5678);
    #2 rst_n = 1'b0;
    #1;
    chk("async_sw_a",   sw_a,            32'h0);
    chk("async_push_a", push_a,          32'h0);
    chk("async_rise_a", rise_a,          32'h0);
    chk("async_tick_a", {31'b0, tick_a}, 32'h0);
    chk("async_sw_b",   sw_b,            32'h0);
    chk("async_push_b", push_b,          32'h0);
    chk("async_tick_b", {31'b0, tick_b}, 32'h0);
    check_model();
    @(negedge clk);
    check_model();
    rst_n = 1'b1;
    // Fresh ticks evaluate at edges 4, 8, 12 after release
    for (int i = 1; i <= 14; i++) begin
      run(1);
      chk("post_rst_sw",   sw_a,   (i >= 12) ? 32'hFF00_FF00 : 32'h0);
      chk("post_rst_push", push_a, (i >= 12) ? 32'hFFFF_FFFF : 32'h0);
      chk("post_rst_rise", rise_a, (i == 13) ? 32'hFFFF_FFFF : 32'h0);
    end

    // Randomized segments: full changes, sparse flips, occasional reset
    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 9))
        0: begin
          #2 rst_n = 1'b0;
          #1 check_model();
          run(1);
          rst_n = 1'b1;
        end
        1, 2, 3: set_in($urandom, $urandom);
        default: set_in(sw_raw ^ ($urandom & $urandom & $urandom),
                        (push_raw ^ PUSH_XOR) ^ ($urandom & $urandom));
      endcase
      run($urandom_range(1, 30));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
